// File: rtl/nibble_datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_datapath_pkg
//  Description : Shared nibble-processor definitions (opcodes, default widths)
//  Revision    : 1.0  initial release
// ============================================================================
package nibble_datapath_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 4;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_ADD   = 2'b01,
      OP_HALT0 = 2'b10,
      OP_HALT1 = 2'b11
   } op_e;

   // True for either halt encoding.
   function automatic logic is_halt(input logic [1:0] op);
      return (op == OP_HALT0) || (op == OP_HALT1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_datapath_imem.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_imem
//  Description : Instruction memory, synchronous write, combinational read.
//                Contents are deliberately not reset so a program survives.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_imem
   import nibble_datapath_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [ADDR_W-1:0]   i_waddr,
   input  logic [DATA_W+1:0]   i_wdata,
   input  logic [ADDR_W-1:0]   i_raddr,
   output logic [DATA_W+1:0]   o_rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W+1:0] r_mem [DEPTH];

   // Program-load write port; a same-edge read sees the old word.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/nibble_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_datapath
//  Description : Nibble processor datapath: PC, IR, accumulator with carry,
//                halt flag, driven by fetch/exec strobes from a controller.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_datapath
   import nibble_datapath_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fetch,
   input  logic                exec,
   input  logic                prog_we,
   input  logic [ADDR_W-1:0]   prog_addr,
   input  logic [DATA_W+1:0]   prog_data,
   output logic [1:0]          op,
   output logic [ADDR_W-1:0]   pc,
   output logic [DATA_W-1:0]   acc,
   output logic                carry,
   output logic                halted
);

   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W+1:0] r_ir;
   logic [DATA_W-1:0] r_acc;
   logic              r_carry;
   logic              r_halted;

   logic [DATA_W+1:0] w_fetch_word;
   logic [1:0]        w_ir_op;
   logic [DATA_W-1:0] w_ir_imm;
   logic [DATA_W:0]   w_sum;
   logic              w_do_fetch;
   logic              w_do_add;

   nibble_imem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_imem (
      .clk     (clk),
      .i_we    (prog_we),
      .i_waddr (prog_addr),
      .i_wdata (prog_data),
      .i_raddr (r_pc),
      .o_rdata (w_fetch_word)
   );

   assign w_ir_op  = r_ir[DATA_W+1 -: 2];
   assign w_ir_imm = r_ir[DATA_W-1:0];

   // Fetch wins over exec; everything freezes once halted.
   always_comb begin
      w_do_fetch = 1'b0;
      w_do_add   = 1'b0;
      w_sum      = {1'b0, r_acc} + {1'b0, w_ir_imm};
      if (!r_halted) begin
         w_do_fetch = fetch;
         w_do_add   = exec && !fetch && (w_ir_op == OP_ADD);
      end
   end

   // Fetch path: load IR, advance PC (natural wrap), latch halt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc     <= '0;
         r_ir     <= '0;
         r_halted <= 1'b0;
      end else if (w_do_fetch) begin
         r_ir     <= w_fetch_word;
         r_pc     <= r_pc + ADDR_W'(1);
         r_halted <= is_halt(w_fetch_word[DATA_W+1 -: 2]);
      end
   end

   // Execute path: ADD updates carry and accumulator together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
      end else if (w_do_add) begin
         {r_carry, r_acc} <= w_sum;
      end
   end

   assign op     = w_ir_op;
   assign pc     = r_pc;
   assign acc    = r_acc;
   assign carry  = r_carry;
   assign halted = r_halted;

endmodule
`default_nettype wire
